// File: rtl/analogue_decimator_mc.sv
// Multi-lane power-of-two decimator: subsample, boxcar average, peak-max and peak-min.
// All lanes share one frame counter and one per-frame latched ratio/mode.
module analogue_decimator_mc #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned X_WIDTH        = 8,
    parameter int unsigned Y_WIDTH        = 12,
    parameter int unsigned PRECISION      = 16,
    parameter int unsigned MAX_RATIO_LOG2 = 8,
    localparam int unsigned RatioW = (MAX_RATIO_LOG2 > 0) ? $clog2(MAX_RATIO_LOG2 + 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic [RatioW-1:0]            ratio_log2_i,
    input  logic [1:0]                   mode_i,
    input  logic [CHANNELS*X_WIDTH-1:0]  x_i,
    input  logic                         x_valid_i,
    output logic [CHANNELS*Y_WIDTH-1:0]  y_o,
    output logic                         y_valid_o,
    output logic                         frame_start_o
);

    localparam int unsigned AccW = PRECISION + MAX_RATIO_LOG2;
    localparam int unsigned CntW = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;

    typedef enum logic [1:0] {
        ModeSub = 2'b00,
        ModeAvg = 2'b01,
        ModeMax = 2'b10,
        ModeMin = 2'b11
    } mode_e;

    logic [CntW-1:0]             count_q, count_d;
    logic [RatioW-1:0]           ratio_q, ratio_d;
    mode_e                       mode_q, mode_d;
    logic signed [AccW-1:0]      acc_q [CHANNELS];
    logic signed [AccW-1:0]      acc_d [CHANNELS];
    logic [CHANNELS*Y_WIDTH-1:0] y_q, y_d;
    logic                        y_valid_q, y_valid_d;
    logic                        fs_q, fs_d;

    logic signed [PRECISION-1:0] x_al   [CHANNELS];
    logic signed [AccW-1:0]      x_ext  [CHANNELS];
    logic signed [AccW-1:0]      acc_nx [CHANNELS];
    logic signed [PRECISION-1:0] res    [CHANNELS];
    logic [CHANNELS*Y_WIDTH-1:0] y_new;

    logic              start;
    logic [RatioW-1:0] ratio_clamp, ratio_eff;
    mode_e             mode_eff;
    logic [CntW:0]     frame_len;
    logic [CntW-1:0]   last_idx;

    // Per-lane input alignment into PRECISION and output alignment into Y_WIDTH
    for (genvar lane = 0; lane < CHANNELS; lane++) begin : g_lane
        logic [X_WIDTH-1:0] x_lane;
        assign x_lane = x_i[lane*X_WIDTH +: X_WIDTH];

        if (X_WIDTH < PRECISION) begin : g_x_pad
            assign x_al[lane] = {x_lane, {(PRECISION - X_WIDTH){1'b0}}};
        end else if (X_WIDTH == PRECISION) begin : g_x_eq
            assign x_al[lane] = x_lane;
        end else begin : g_x_trunc
            logic unused_x_lsbs;
            assign unused_x_lsbs = ^x_lane[X_WIDTH-PRECISION-1:0];
            assign x_al[lane] = x_lane[X_WIDTH-1 -: PRECISION];
        end

        assign x_ext[lane] = AccW'(x_al[lane]);

        if (Y_WIDTH < PRECISION) begin : g_y_trunc
            logic unused_res_lsbs;
            assign unused_res_lsbs = ^res[lane][PRECISION-Y_WIDTH-1:0];
            assign y_new[lane*Y_WIDTH +: Y_WIDTH] = res[lane][PRECISION-1 -: Y_WIDTH];
        end else if (Y_WIDTH == PRECISION) begin : g_y_eq
            assign y_new[lane*Y_WIDTH +: Y_WIDTH] = res[lane];
        end else begin : g_y_pad
            assign y_new[lane*Y_WIDTH +: Y_WIDTH] = {res[lane], {(Y_WIDTH - PRECISION){1'b0}}};
        end
    end

    // Config seen by the current sample: live inputs on frame sample 0, latched copy otherwise
    assign start       = (count_q == '0);
    assign ratio_clamp = (ratio_log2_i > RatioW'(MAX_RATIO_LOG2)) ? RatioW'(MAX_RATIO_LOG2)
                                                                   : ratio_log2_i;
    assign ratio_eff   = start ? ratio_clamp : ratio_q;
    assign mode_eff    = start ? mode_e'(mode_i) : mode_q;
    assign frame_len   = (CntW + 1)'(1) << ratio_eff;
    assign last_idx    = CntW'(frame_len - (CntW + 1)'(1));

    // Next-state: per-lane accumulate/peak/first-sample update and frame completion
    always_comb begin
        count_d   = count_q;
        ratio_d   = ratio_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        fs_d      = 1'b0;

        // acc holds the running sum, running extreme, or the first sample, depending on mode
        for (int i = 0; i < CHANNELS; i++) begin
            acc_nx[i] = acc_q[i];
            if (start) begin
                acc_nx[i] = x_ext[i];
            end else begin
                unique case (mode_eff)
                    ModeSub: acc_nx[i] = acc_q[i];
                    ModeAvg: acc_nx[i] = acc_q[i] + x_ext[i];
                    ModeMax: acc_nx[i] = (x_ext[i] > acc_q[i]) ? x_ext[i] : acc_q[i];
                    ModeMin: acc_nx[i] = (x_ext[i] < acc_q[i]) ? x_ext[i] : acc_q[i];
                    default: acc_nx[i] = acc_q[i];
                endcase
            end
            if (mode_eff == ModeAvg) begin
                res[i] = PRECISION'(acc_nx[i] >>> ratio_eff);
            end else begin
                res[i] = PRECISION'(acc_nx[i]);
            end
        end

        if (clear_i) begin
            count_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = '0;
            end
        end else if (x_valid_i) begin
            acc_d = acc_nx;
            if (start) begin
                ratio_d = ratio_clamp;
                mode_d  = mode_eff;
                fs_d    = 1'b1;
            end
            if (count_q == last_idx) begin
                count_d   = '0;
                y_d       = y_new;
                y_valid_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            ratio_q   <= '0;
            mode_q    <= ModeSub;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            fs_q      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            ratio_q   <= ratio_d;
            mode_q    <= mode_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            fs_q      <= fs_d;
            acc_q     <= acc_d;
        end
    end

    assign y_o           = y_q;
    assign y_valid_o     = y_valid_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_analogue_decimator_mc.sv
// Bench for analogue_decimator_mc: vector table, directed corner sequences, random vs model.
module tb_analogue_decimator_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear;
    logic [3:0]  ratio_log2;
    logic [1:0]  mode;
    logic [31:0] x;
    logic        x_valid;
    logic [47:0] y;
    logic        y_valid;
    logic        frame_start;

    // Wide-input instance: X_WIDTH=20 truncated into PRECISION=16
    logic        w_valid;
    logic [3:0]  w_ratio;
    logic [1:0]  w_mode;
    logic [19:0] w_x;
    logic [11:0] w_y;
    logic        w_yv;
    logic        w_fs;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_n;
    int m_r;
    int m_mode;
    int samp [4][256];
    int exp_y [4];
    bit exp_v;
    bit exp_fs;

    typedef struct packed {
        bit clr; int r; int m; bit v;
        int x0; int x1; int x23;
        bit ev; bit efs;
        int ey0; int ey1; int ey23;
    } vec_t;
    vec_t vecs[$];

    analogue_decimator_mc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear),
        .ratio_log2_i (ratio_log2),
        .mode_i       (mode),
        .x_i          (x),
        .x_valid_i    (x_valid),
        .y_o          (y),
        .y_valid_o    (y_valid),
        .frame_start_o(frame_start)
    );

    analogue_decimator_mc #(
        .CHANNELS      (1),
        .X_WIDTH       (20),
        .Y_WIDTH       (12),
        .PRECISION     (16),
        .MAX_RATIO_LOG2(8)
    ) dut_wide (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (1'b0),
        .ratio_log2_i (w_ratio),
        .mode_i       (w_mode),
        .x_i          (w_x),
        .x_valid_i    (w_valid),
        .y_o          (w_y),
        .y_valid_o    (w_yv),
        .frame_start_o(w_fs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ylane(input int l);
        return int'($signed(y[l*12 +: 12]));
    endfunction

    // Floor division (rounds toward -inf)
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic vec_t mk(input bit clr, input int r, input int m, input bit v,
                                input int x0, input int x1, input int x23, input bit ev,
                                input bit efs, input int ey0, input int ey1, input int ey23);
        vec_t t;
        t.clr = clr; t.r = r; t.m = m; t.v = v;
        t.x0 = x0; t.x1 = x1; t.x23 = x23;
        t.ev = ev; t.efs = efs; t.ey0 = ey0; t.ey1 = ey1; t.ey23 = ey23;
        return t;
    endfunction

    task automatic model_reset();
        m_n = 0; m_r = 0; m_mode = 0; exp_v = 0; exp_fs = 0;
        for (int l = 0; l < 4; l++) exp_y[l] = 0;
    endtask

    // Frame-level model: collect N aligned samples per lane, then reduce by mode
    task automatic model_step(input bit clr, input int r, input int m, input bit v,
                              input int xs [4]);
        int acc;
        exp_v  = 0;
        exp_fs = 0;
        if (clr) begin
            m_n = 0;
        end else if (v) begin
            if (m_n == 0) begin
                m_r    = (r > 8) ? 8 : r;
                m_mode = m;
                exp_fs = 1;
            end
            for (int l = 0; l < 4; l++) samp[l][m_n] = xs[l] * 256;
            m_n++;
            if (m_n == (1 << m_r)) begin
                for (int l = 0; l < 4; l++) begin
                    acc = samp[l][0];
                    for (int k = 1; k < m_n; k++) begin
                        case (m_mode)
                            1: acc = acc + samp[l][k];
                            2: if (samp[l][k] > acc) acc = samp[l][k];
                            3: if (samp[l][k] < acc) acc = samp[l][k];
                            default: ;
                        endcase
                    end
                    if (m_mode == 1) acc = fdiv(acc, m_n);
                    exp_y[l] = fdiv(acc, 16);
                end
                exp_v = 1;
                m_n   = 0;
            end
        end
    endtask

    task automatic cycle(input bit clr, input int r, input int m, input bit v,
                         input int x0, input int x1, input int x2, input int x3);
        int xs [4];
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        clear      = clr;
        ratio_log2 = r[3:0];
        mode       = m[1:0];
        x_valid    = v;
        x          = {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
        @(posedge clk);
        model_step(clr, r, m, v, xs);
        #1;
        check("model y_valid", int'(y_valid), int'(exp_v));
        check("model frame_start", int'(frame_start), int'(exp_fs));
        for (int l = 0; l < 4; l++) check($sformatf("model y[%0d]", l), ylane(l), exp_y[l]);
    endtask

    initial begin
        int strobes;
        int rx [4];

        clear = 0; ratio_log2 = 0; mode = 0; x = 0; x_valid = 0;
        w_valid = 0; w_ratio = 0; w_mode = 0; w_x = 0;
        model_reset();

        // Directed vectors: clr r m v x0 x1 x23 | y_valid frame_start y0 y1 y23
        vecs.push_back(mk(0, 2, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 1, 0, 0, 1, 0, 16, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 1, 16, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 0, 16, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 0, 0, 16, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, -3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, -2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, -1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, 4, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 2, 1, 0, -5, 0, 1, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 1, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, -3, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, 1, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, -2, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, -1, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, 4, 0, 0, 0, 0, 64, 0));
        vecs.push_back(mk(0, 3, 3, 1, 0, -5, 0, 1, 0, 0, -80, 0));
        vecs.push_back(mk(0, 0, 0, 1, -3, -3, -3, 1, 1, -48, -48, -48));
        vecs.push_back(mk(0, 0, 0, 1, -3, -3, -3, 1, 1, -48, -48, -48));
        vecs.push_back(mk(0, 0, 0, 0, 7, 7, 7, 0, 0, -48, -48, -48));
        vecs.push_back(mk(0, 0, 0, 1, -3, -3, -3, 1, 1, -48, -48, -48));

        repeat (2) @(posedge clk);
        #1;
        check("reset y_valid", int'(y_valid), 0);
        check("reset frame_start", int'(frame_start), 0);
        check("reset y", int'(y), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].clr, vecs[i].r, vecs[i].m, vecs[i].v,
                  vecs[i].x0, vecs[i].x1, vecs[i].x23, vecs[i].x23);
            check($sformatf("vec%0d y_valid", i), int'(y_valid), int'(vecs[i].ev));
            check($sformatf("vec%0d frame_start", i), int'(frame_start), int'(vecs[i].efs));
            check($sformatf("vec%0d y0", i), ylane(0), vecs[i].ey0);
            check($sformatf("vec%0d y1", i), ylane(1), vecs[i].ey1);
            check($sformatf("vec%0d y2", i), ylane(2), vecs[i].ey23);
            check($sformatf("vec%0d y3", i), ylane(3), vecs[i].ey23);
        end

        // Ratio change mid-frame: current frame stays 4 samples, next is 2
        cycle(0, 2, 1, 1, 1, 0, 0, 0);
        cycle(0, 2, 1, 1, 2, 0, 0, 0);
        cycle(0, 1, 1, 1, 3, 0, 0, 0);
        check("ratio chg 3rd no strobe", int'(y_valid), 0);
        cycle(0, 1, 1, 1, 4, 0, 0, 0);
        check("ratio chg 4th strobe", int'(y_valid), 1);
        check("ratio chg avg y0", ylane(0), 40);
        cycle(0, 1, 1, 1, 5, 0, 0, 0);
        check("ratio 1 first no strobe", int'(y_valid), 0);
        cycle(0, 1, 1, 1, 7, 0, 0, 0);
        check("ratio 1 second strobe", int'(y_valid), 1);
        check("ratio 1 avg y0", ylane(0), 96);

        // Clear together with the 3rd sample drops the frame
        cycle(0, 2, 0, 1, 10, 0, 0, 0);
        cycle(0, 2, 0, 1, 20, 0, 0, 0);
        cycle(1, 2, 0, 1, 30, 0, 0, 0);
        check("clear no strobe", int'(y_valid), 0);
        check("clear no frame_start", int'(frame_start), 0);
        check("clear y held", ylane(0), 96);
        strobes = 0;
        cycle(0, 2, 0, 1, 40, 0, 0, 0);
        check("after clear frame_start", int'(frame_start), 1);
        strobes += int'(y_valid);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 2, 0, 1, 50 + 10 * k, 0, 0, 0);
            strobes += int'(y_valid);
        end
        check("after clear strobe count", strobes, 1);
        check("after clear subsample y0", ylane(0), 640);

        // Async reset right after a strobe and mid-frame
        cycle(0, 0, 0, 1, 5, 5, 5, 5);
        check("pre-reset strobe", int'(y_valid), 1);
        rst_n = 1'b0;
        #2;
        check("async reset y", int'(y), 0);
        check("async reset y_valid", int'(y_valid), 0);
        model_reset();
        clear = 0; x_valid = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(0, 2, 1, 1, 9, 9, 9, 9);
        cycle(0, 2, 1, 1, 9, 9, 9, 9);
        rst_n = 1'b0;
        #2;
        check("reset mid-frame y_valid", int'(y_valid), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle(0, 2, 2, 1, k, -k, 2 * k, -2 * k);
        check("post-reset fresh frame strobe", int'(y_valid), 1);
        check("post-reset max y0", ylane(0), 48);

        // Ratio above MAX_RATIO_LOG2 clamps to 256-sample frames
        for (int k = 0; k < 256; k++) begin
            for (int l = 0; l < 4; l++) rx[l] = int'($urandom_range(0, 255)) - 128;
            cycle(0, 15, 1, 1, rx[0], rx[1], rx[2], rx[3]);
        end
        check("clamp frame strobe", int'(y_valid), 1);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            for (int l = 0; l < 4; l++) rx[l] = int'($urandom_range(0, 255)) - 128;
            cycle(($urandom_range(0, 31) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  rx[0], rx[1], rx[2], rx[3]);
        end

        // Wide instance: average of 256 x 0x7FFFF
        clear = 0; x_valid = 0;
        strobes = 0;
        w_ratio = 4'd8; w_mode = 2'b01; w_x = 20'h7FFFF; w_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            strobes += int'(w_yv);
        end
        w_valid = 1'b0;
        check("wide strobe count", strobes, 1);
        check("wide last-cycle strobe", int'(w_yv), 1);
        check("wide avg y", int'(w_y), 'h7FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
